// File: rtl/microstep_sequencer_pkg.sv
// Shared types and helpers for the SAP-style microstep sequencer.
package sap1_seq_pkg;

    typedef enum logic [1:0] {
        SEQ_FETCH,
        SEQ_EXECUTE,
        SEQ_HALTED
    } seq_state_t;

    // Forces a ROM-supplied length into [fetch_steps, max_steps].
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned fetch_steps,
                                              input int unsigned max_steps);
        if (len < fetch_steps)
            return fetch_steps;
        else if (len > max_steps)
            return max_steps;
        else
            return len;
    endfunction

endpackage

// File: rtl/microstep_sequencer_retire_counter.sv
// Retired-instruction counter with a one-cycle done pulse.
module retire_counter #(
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   retire,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] count
);

    // The pulse follows every clock edge so it clears even when the sequencer is not enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done  <= 1'b0;
            count <= '0;
        end else begin
            done <= retire;
            if (retire)
                count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/microstep_sequencer.sv
// Microstep sequencer: FETCH/EXECUTE/HALTED control with retire counting.
// Optional single-step gating is enabled by defining SAP1_SINGLE_STEP_EN.
module microstep_sequencer
    import sap1_seq_pkg::*;
#(
    parameter int unsigned INSTRUCTION_STEPS = 8,
    parameter int unsigned FETCH_STEPS       = 2,
    parameter int unsigned COUNT_WIDTH       = 16,
    localparam int unsigned STEP_WIDTH       = $clog2(INSTRUCTION_STEPS),
    localparam int unsigned LEN_WIDTH        = $clog2(INSTRUCTION_STEPS + 1)
) (
    input  logic                   mclk,
    input  logic                   i_rst_n,
    input  logic                   mclk_en,
    input  logic [LEN_WIDTH-1:0]   i_len,
    input  logic                   i_adv,
    input  logic                   i_stall,
    input  logic                   i_halt,
    input  logic                   i_resume,
`ifdef SAP1_SINGLE_STEP_EN
    input  logic                   i_single_mode,
    input  logic                   i_step_req,
`endif
    output logic [STEP_WIDTH-1:0]  o_step,
    output logic                   o_fetch,
    output logic                   o_last,
    output logic                   o_halted,
    output logic                   o_instr_done,
    output logic [COUNT_WIDTH-1:0] o_instr_count
);

    seq_state_t            state, state_nxt;
    logic [STEP_WIDTH-1:0] step_nxt;
    logic [LEN_WIDTH-1:0]  cap_len, cap_len_nxt;
    logic [LEN_WIDTH-1:0]  clamped_len;
    logic                  hold;
    logic                  retire;

`ifdef SAP1_SINGLE_STEP_EN
    assign hold = i_single_mode & ~i_step_req;
`else
    assign hold = 1'b0;
`endif

    assign clamped_len = LEN_WIDTH'(clamp_len(32'(i_len), FETCH_STEPS, INSTRUCTION_STEPS));
    assign o_fetch     = (32'(o_step) < FETCH_STEPS);

    always_comb begin
        o_last = 1'b0;
        case (state)
            SEQ_FETCH:   o_last = (o_step == STEP_WIDTH'(FETCH_STEPS - 1)) &&
                                  (clamped_len <= LEN_WIDTH'(FETCH_STEPS));
            SEQ_EXECUTE: o_last = (LEN_WIDTH'(o_step) == cap_len - LEN_WIDTH'(1));
            default:     o_last = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        step_nxt    = o_step;
        cap_len_nxt = cap_len;
        retire      = 1'b0;
        if (mclk_en) begin
            if (state == SEQ_HALTED) begin
                if (i_resume) begin
                    state_nxt = SEQ_FETCH;
                    step_nxt  = '0;
                    retire    = 1'b1;
                end
            end else if (hold) begin
                state_nxt = state;
            end else if (i_halt) begin
                state_nxt = SEQ_HALTED;
            end else if (i_stall) begin
                state_nxt = state;
            end else if (i_adv || o_last) begin
                state_nxt = SEQ_FETCH;
                step_nxt  = '0;
                retire    = 1'b1;
            end else begin
                step_nxt = o_step + 1'b1;
                // Length is sampled only when crossing into EXECUTE; a fetch-only opcode never gets here.
                if (o_step == STEP_WIDTH'(FETCH_STEPS - 1)) begin
                    state_nxt   = SEQ_EXECUTE;
                    cap_len_nxt = clamped_len;
                end
            end
        end
    end

    always_ff @(posedge mclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= SEQ_FETCH;
            o_step   <= '0;
            cap_len  <= LEN_WIDTH'(INSTRUCTION_STEPS);
            o_halted <= 1'b0;
        end else begin
            state    <= state_nxt;
            o_step   <= step_nxt;
            cap_len  <= cap_len_nxt;
            o_halted <= (state_nxt == SEQ_HALTED);
        end
    end

    retire_counter #(
        .COUNT_WIDTH(COUNT_WIDTH)
    ) u_retire_counter (
        .clk    (mclk),
        .rst_n  (i_rst_n),
        .retire (retire),
        .done   (o_instr_done),
        .count  (o_instr_count)
    );

endmodule

// File: tb/tb_microstep_sequencer.sv
// Self-checking bench for microstep_sequencer: vector table, corner sequences, random vs model.
module tb_microstep_sequencer;

    localparam int F  = 2;
    localparam int N  = 8;
    localparam int CW = 4;

    logic          mclk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [3:0]    len;
    logic          adv, stall, halt, resume;
    logic          single_mode, step_req;
    logic [2:0]    step;
    logic          fetch, last, halted, done;
    logic [CW-1:0] count;

    microstep_sequencer #(
        .INSTRUCTION_STEPS(N),
        .FETCH_STEPS(F),
        .COUNT_WIDTH(CW)
    ) dut (
        .mclk          (mclk),
        .i_rst_n       (rst_n),
        .mclk_en       (en),
        .i_len         (len),
        .i_adv         (adv),
        .i_stall       (stall),
        .i_halt        (halt),
        .i_resume      (resume),
`ifdef SAP1_SINGLE_STEP_EN
        .i_single_mode (single_mode),
        .i_step_req    (step_req),
`endif
        .o_step        (step),
        .o_fetch       (fetch),
        .o_last        (last),
        .o_halted      (halted),
        .o_instr_done  (done),
        .o_instr_count (count)
    );

    always #5 mclk = ~mclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference ----------------
    int m_step, m_len, m_cnt;
    bit m_halted, m_done;

    function automatic int clampm(input int l);
        return (l < F) ? F : ((l > N) ? N : l);
    endfunction

    function automatic bit m_last(input int l);
        if (m_halted)   return 1'b0;
        if (m_step < F) return (m_step == F - 1) && (clampm(l) <= F);
        return m_step == m_len - 1;
    endfunction

    task automatic model_reset();
        m_step = 0; m_len = N; m_cnt = 0; m_halted = 0; m_done = 0;
    endtask

    task automatic model_edge(input bit e, input int l, input bit a, input bit s,
                              input bit h, input bit r);
        bit ret;
        bit lst;
        ret = 0;
        lst = m_last(l);
        m_done = 0;
        if (e) begin
            if (m_halted) begin
                if (r) begin m_halted = 0; m_step = 0; ret = 1; end
            end else if (single_mode && !step_req) begin
                ret = 0;
            end else if (h) begin
                m_halted = 1;
            end else if (s) begin
                ret = 0;
            end else if (a || lst) begin
                m_step = 0; ret = 1;
            end else begin
                if (m_step == F - 1) m_len = clampm(l);
                m_step++;
            end
        end
        if (ret) begin
            m_cnt  = (m_cnt + 1) % (1 << CW);
            m_done = 1;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_step"},   step,   m_step);
        check({tag, "_fetch"},  fetch,  m_step < F);
        check({tag, "_last"},   last,   m_last(int'(len)));
        check({tag, "_halted"}, halted, m_halted);
        check({tag, "_done"},   done,   m_done);
        check({tag, "_count"},  count,  m_cnt);
    endtask

    // Apply inputs at a negedge, compare, then advance one clock.
    task automatic drive(input string tag, input bit e, input int l, input bit a,
                         input bit s, input bit h, input bit r);
        en = e; len = 4'(l); adv = a; stall = s; halt = h; resume = r;
        #1;
        check_model(tag);
        model_edge(e, l, a, s, h, r);
        @(negedge mclk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b1; len = '0; adv = 0; stall = 0; halt = 0; resume = 0;
        model_reset();
        #1;
        check_model("reset");
        @(negedge mclk);
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit en; int len; bit adv, stall, halt, resume;
        int step; bit fetch, last, halted, done; int cnt;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input bit e, input int l, input bit a, input bit s,
                                input bit h, input bit r, input int st, input bit fe,
                                input bit la, input bit ha, input bit dn, input int c);
        vec_t v;
        v.en = e; v.len = l; v.adv = a; v.stall = s; v.halt = h; v.resume = r;
        v.step = st; v.fetch = fe; v.last = la; v.halted = ha; v.done = dn; v.cnt = c;
        vecs.push_back(v);
    endfunction

    initial begin
        single_mode = 1'b0; step_req = 1'b0;
        rst_n = 1'b0;
        en = 1'b1; len = '0; adv = 0; stall = 0; halt = 0; resume = 0;
        @(negedge mclk);
        do_reset();

        //   en len adv stl hlt res | step fe last hlt done cnt
        add(1, 5, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0);
        add(1, 5, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0);
        add(1, 5, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0);
        add(1, 5, 0, 0, 0, 0,   3, 0, 0, 0, 0, 0);
        add(1, 5, 0, 0, 0, 0,   4, 0, 1, 0, 0, 0);
        add(1, 6, 0, 0, 0, 0,   0, 1, 0, 0, 1, 1);
        add(1, 6, 0, 0, 0, 0,   1, 1, 0, 0, 0, 1);
        add(1, 6, 0, 0, 0, 0,   2, 0, 0, 0, 0, 1);
        add(1, 6, 1, 0, 0, 0,   3, 0, 0, 0, 0, 1);
        add(1, 6, 0, 0, 0, 0,   0, 1, 0, 0, 1, 2);
        add(1, 6, 0, 0, 0, 0,   1, 1, 0, 0, 0, 2);
        add(1, 6, 0, 1, 0, 0,   2, 0, 0, 0, 0, 2);
        add(1, 6, 0, 1, 0, 0,   2, 0, 0, 0, 0, 2);
        add(1, 6, 0, 1, 0, 0,   2, 0, 0, 0, 0, 2);
        add(1, 6, 0, 0, 0, 0,   2, 0, 0, 0, 0, 2);
        add(1, 6, 0, 0, 0, 0,   3, 0, 0, 0, 0, 2);
        add(1, 6, 0, 0, 1, 0,   4, 0, 0, 0, 0, 2);
        add(1, 6, 0, 0, 0, 0,   4, 0, 0, 1, 0, 2);
        add(1, 6, 0, 0, 0, 0,   4, 0, 0, 1, 0, 2);
        add(1, 6, 0, 0, 0, 1,   4, 0, 0, 1, 0, 2);
        add(1, 6, 0, 0, 0, 0,   0, 1, 0, 0, 1, 3);

        for (int i = 0; i < vecs.size(); i++) begin
            en = vecs[i].en; len = 4'(vecs[i].len); adv = vecs[i].adv;
            stall = vecs[i].stall; halt = vecs[i].halt; resume = vecs[i].resume;
            #1;
            check($sformatf("vec%0d_step", i),   step,   vecs[i].step);
            check($sformatf("vec%0d_fetch", i),  fetch,  vecs[i].fetch);
            check($sformatf("vec%0d_last", i),   last,   vecs[i].last);
            check($sformatf("vec%0d_halted", i), halted, vecs[i].halted);
            check($sformatf("vec%0d_done", i),   done,   vecs[i].done);
            check($sformatf("vec%0d_count", i),  count,  vecs[i].cnt);
            @(negedge mclk);
        end

        // Fetch-only opcodes: length 0 clamps to FETCH_STEPS.
        do_reset();
        for (int i = 0; i < 8; i++) drive("fonly", 1, 0, 0, 0, 0, 0);
        check("fonly_count4", count, 4);

        // Oversized length clamps to INSTRUCTION_STEPS.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("clamp15_step%0d", i), step, i);
            drive("clamp15", 1, 15, 0, 0, 0, 0);
        end
        check("clamp15_wrap", step, 0);

        // Long halt, then resume.
        do_reset();
        for (int i = 0; i < 4; i++) drive("hseq", 1, 6, 0, 0, 0, 0);
        drive("hseq_halt", 1, 6, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) drive("hseq_hold", 1, 6, 0, 0, i % 2, 0);
        check("hseq_held_step", step, 4);
        check("hseq_held_cnt", count, 0);
        drive("hseq_resume", 1, 6, 0, 0, 0, 1);
        check("hseq_res_step", step, 0);
        check("hseq_res_done", done, 1);
        check("hseq_res_cnt", count, 1);

        // Async reset at step 3 with count 7.
        do_reset();
        for (int i = 0; i < 14; i++) drive("ar_pre", 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive("ar_run", 1, 5, 0, 0, 0, 0);
        check("ar_step3", step, 3);
        check("ar_cnt7", count, 7);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_step_now", step, 0);
        check("ar_cnt_now", count, 0);
        @(negedge mclk);
        rst_n = 1'b1;
        model_reset();

        // Clock enable 1-of-3, done pulse must still clear on a disabled edge.
        for (int i = 0; i < 9; i++) drive("en3", (i % 3) == 0, 8, 0, 0, 0, 0);
        check("en3_step", step, 3);

        // Counter wrap at 2^COUNT_WIDTH.
        do_reset();
        for (int i = 0; i < 30; i++) drive("wrap", 1, 0, 0, 0, 0, 0);
        check("wrap_cnt15", count, 15);
        drive("wrap", 1, 0, 0, 0, 0, 0);
        drive("wrap", 1, 0, 0, 0, 0, 0);
        check("wrap_cnt0", count, 0);
        check("wrap_done", done, 1);

`ifdef SAP1_SINGLE_STEP_EN
        do_reset();
        single_mode = 1'b1; step_req = 1'b0;
        for (int i = 0; i < 3; i++) drive("ss_idle", 1, 5, 0, 0, 0, 0);
        check("ss_idle_step", step, 0);
        step_req = 1'b1;
        drive("ss_req", 1, 5, 0, 0, 0, 0);
        step_req = 1'b0;
        check("ss_req_step", step, 1);
        drive("ss_after", 1, 5, 0, 0, 0, 0);
        check("ss_after_step", step, 1);
        single_mode = 1'b0;
`endif

        // Random stimulus against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
`ifdef SAP1_SINGLE_STEP_EN
            single_mode = ($urandom_range(0, 9) < 2);
            step_req    = $urandom_range(0, 1);
`endif
            drive("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 15),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/microstep_sequencer.md
Name: microstep_sequencer

Overview:
- Next-generation instruction step sequencer for the SAP-style CPU control path.
- Tracks the current microstep and splits each instruction into a fixed FETCH phase and a variable-length EXECUTE phase, whose length comes from the microcode ROM.
- Supports early termination, stall, sticky halt with resume, and retired-instruction counting.
- Sits between the instruction register/microcode ROM and the control-word decoder; o_step indexes the ROM.

Parameters:
INSTRUCTION_STEPS, 8, maximum microsteps per instruction including fetch (>=2)
FETCH_STEPS, 2, fixed fetch microsteps (1 <= FETCH_STEPS < INSTRUCTION_STEPS)
COUNT_WIDTH, 16, width of retired-instruction counter
STEP_WIDTH (localparam), $clog2(INSTRUCTION_STEPS)
LEN_WIDTH (localparam), $clog2(INSTRUCTION_STEPS+1)

Ports:
mclk  in  1  system clock
i_rst_n  in  1  reset, asynchronous assert, active-low
mclk_en  in  1  clock enable; state changes only on edges with mclk_en=1
i_len  in  LEN_WIDTH  total steps of current opcode (fetch+execute), from microcode ROM
i_adv  in  1  microcode "end instruction now"
i_stall  in  1  hold current step (memory/IO wait)
i_halt  in  1  microcode HLT; enter HALTED
i_resume  in  1  leave HALTED
o_step  out  STEP_WIDTH  current microstep
o_fetch  out  1  o_step < FETCH_STEPS
o_last  out  1  current step is final step of instruction
o_halted  out  1  in HALTED state
o_instr_done  out  1  one-cycle pulse after each retire
o_instr_count  out  COUNT_WIDTH  retired instructions, wraps modulo 2^COUNT_WIDTH

Behaviour:
- Reset (i_rst_n=0, async): state FETCH, step 0, captured len = INSTRUCTION_STEPS, o_halted=0, o_instr_done=0, o_instr_count=0.
- States: FETCH, EXECUTE, HALTED. o_step, o_halted, o_instr_done and o_instr_count are registered. o_fetch and o_last are decoded from registers.
- Length capture: on the enabled edge leaving step FETCH_STEPS-1, latch eff_len:
  - eff_len = i_len, clamped into [FETCH_STEPS, INSTRUCTION_STEPS].
  - eff_len == FETCH_STEPS means a fetch-only instruction: o_last is high at step FETCH_STEPS-1, and the sequencer retires and returns to step 0.
- o_last:
  - in FETCH: (step == FETCH_STEPS-1) & (clamped i_len <= FETCH_STEPS)
  - in EXECUTE: step == eff_len-1
- Enabled-edge priority, highest first:
  1. HALTED: hold the step. If i_resume: go to FETCH, step 0, retire. Otherwise stay.
  2. i_halt: go to HALTED, hold step, no retire.
  3. i_stall: hold everything.
  4. i_adv or o_last: step 0, FETCH, retire.
  5. Otherwise step+1; FETCH→EXECUTE when step+1 == FETCH_STEPS.
- i_adv during FETCH is honoured: step 0, retire counted.
- Retire:
  - o_instr_count += 1.
  - o_instr_done = 1 for exactly the next mclk cycle; cleared on the following clock edge regardless of mclk_en.
- mclk_en=0: no state change, except clearing o_instr_done.
- Reset mid-instruction or mid-halt: immediate return to reset values, no retire.
- i_resume outside HALTED: ignored.

Optional Feature:
SAP1_SINGLE_STEP_EN
- Defined:
  - Adds ports i_single_mode (1) and i_step_req (1).
  - When i_single_mode=1, an enabled edge advances only if i_step_req=1; the step, captured length, count and halt update only on such an edge.
  - An edge with i_step_req=0 behaves as stall.
  - HALTED/resume is unaffected by i_step_req.
- Undefined: ports absent; behaviour exactly as above.

Decomposition:
- Package sap1_seq_pkg holds:
  - state enum (SEQ_FETCH, SEQ_EXECUTE, SEQ_HALTED)
  - function clamp_len(i_len, FETCH_STEPS, INSTRUCTION_STEPS)
- One sub-module: retire_counter (COUNT_WIDTH counter plus done-pulse register, async active-low reset).

Test Plan:
1. Defaults, i_len=5, mclk_en=1 continuously → o_step 0,1,2,3,4,0; o_last at step 4; o_instr_done one cycle after the wrap; o_instr_count=1.
2. i_len=0 (clamps to 2) → o_step 0,1,0,1; o_fetch always 1; count increments every 2 enabled edges. i_len=15 → clamps to 8, steps 0..7.
3. i_len=6, i_adv at step 3 → next step 0, count+1. i_stall held 3 enabled edges at step 2 → o_step stays 2, then 3.
4. i_halt at step 4 → o_halted=1, o_step stays 4 for 10 edges, count unchanged. i_resume → step 0, o_halted=0, count+1, o_instr_done pulse.
5. Assert i_rst_n=0 asynchronously at step 3 with count=7 → outputs 0 immediately, without waiting for an mclk edge. Also toggle mclk_en 1-of-3 → steps advance only on enabled edges.
6. With SAP1_SINGLE_STEP_EN and i_single_mode=1: three enabled edges with i_step_req=0 leave the step unchanged; one i_step_req pulse advances by exactly 1. Preset COUNT_WIDTH=4, count=15 → retire wraps to 0.
